// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 sequencer types and opcode constants
package chip8_pkg;

    localparam int PC_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI_REQ  = 3'd1,
        ST_HI_WAIT = 3'd2,
        ST_LO_REQ  = 3'd3,
        ST_LO_WAIT = 3'd4,
        ST_DECODE  = 3'd5,
        ST_EXEC    = 3'd6,
        ST_FAULT   = 3'd7
    } seq_state_t;

    localparam logic [3:0]  OP_JP   = 4'h1;
    localparam logic [3:0]  OP_CALL = 4'h2;
    localparam logic [3:0]  OP_JPV0 = 4'hB;
    localparam logic [15:0] RET     = 16'h00EE;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - PC strobe, memory read and execute handshake bundle
interface pc_sequencer_if;
    import chip8_pkg::*;

    logic [PC_W-1:0] pc_value;
    logic [PC_W-1:0] pc_preload;
    logic            pc_preload_stb;
    logic            pc_jump_next_stb;
    logic            pc_inc_stb;
    logic            mem_rd_stb;
    logic [7:0]      mem_rd_data;
    logic            mem_rd_valid;
    logic [15:0]     opcode;
    logic            opcode_valid;
    logic            exec_done;
    logic            skip_cond;

    modport master (
        input  pc_value, mem_rd_data, mem_rd_valid, exec_done, skip_cond,
        output pc_preload, pc_preload_stb, pc_jump_next_stb, pc_inc_stb,
               mem_rd_stb, opcode, opcode_valid
    );

    modport slave (
        output pc_value, mem_rd_data, mem_rd_valid, exec_done, skip_cond,
        input  pc_preload, pc_preload_stb, pc_jump_next_stb, pc_inc_stb,
               mem_rd_stb, opcode, opcode_valid
    );

endinterface

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address stack; push writes at sp, pop reads at sp-1
module call_stack
    import chip8_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int SP_W = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE    = 1;
    localparam logic [SP_W:0]   DEPTH_ONE = 1;
    localparam logic [SP_W:0]   DEPTH_MAX = (SP_W + 1)'(DEPTH);

    logic [SP_W-1:0] sp;
    logic [SP_W:0]   depth;
    logic [PC_W-1:0] mem [DEPTH];

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == '0);
    assign dout  = mem[sp - SP_ONE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            depth <= '0;
        end else if (push && !full) begin
            sp    <= sp + SP_ONE;
            depth <= depth + DEPTH_ONE;
        end else if (pop && !empty) begin
            sp    <= sp - SP_ONE;
            depth <= depth - DEPTH_ONE;
        end
    end

    // Entries are not reset; only sp/depth define which ones are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - CHIP-8 fetch and flow-control sequencer
module pc_sequencer
    import chip8_pkg::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [7:0]     v0,
    output logic           fault,
    pc_sequencer_if.master bus
);

    seq_state_t      state, state_nxt;
    logic [15:0]     opcode_q;
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_dout;
    logic            is_jp, is_call, is_jpv0, is_ret;

    assign is_jp   = (opcode_q[15:12] == OP_JP);
    assign is_call = (opcode_q[15:12] == OP_CALL);
    assign is_jpv0 = (opcode_q[15:12] == OP_JPV0);
    assign is_ret  = (opcode_q == RET);
    assign bus.opcode = opcode_q;

    call_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (bus.pc_value),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= 16'h0000;
        end else if (state == ST_HI_WAIT && bus.mem_rd_valid) begin
            opcode_q[15:8] <= bus.mem_rd_data;
        end else if (state == ST_LO_WAIT && bus.mem_rd_valid) begin
            opcode_q[7:0] <= bus.mem_rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (run) state_nxt = ST_HI_REQ;
            ST_HI_REQ:  state_nxt = ST_HI_WAIT;
            ST_HI_WAIT: if (bus.mem_rd_valid) state_nxt = ST_LO_REQ;
            ST_LO_REQ:  state_nxt = ST_LO_WAIT;
            ST_LO_WAIT: if (bus.mem_rd_valid) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (is_ret)                   state_nxt = stk_empty ? ST_FAULT : ST_IDLE;
                else if (is_call)             state_nxt = stk_full ? ST_FAULT : ST_IDLE;
                else if (is_jp || is_jpv0)    state_nxt = ST_IDLE;
                else                          state_nxt = ST_EXEC;
            end
            ST_EXEC:    if (bus.exec_done) state_nxt = ST_IDLE;
            ST_FAULT:   state_nxt = ST_FAULT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Preload target is decoded from the latched opcode so it is valid with the strobe.
    always_comb begin
        bus.pc_preload       = opcode_q[11:0];
        bus.pc_preload_stb   = 1'b0;
        bus.pc_jump_next_stb = 1'b0;
        bus.pc_inc_stb       = 1'b0;
        bus.mem_rd_stb       = 1'b0;
        bus.opcode_valid     = 1'b0;
        stk_push             = 1'b0;
        stk_pop              = 1'b0;
        fault                = 1'b0;
        if (is_ret) begin
            bus.pc_preload = stk_dout;
        end else if (is_jpv0) begin
            bus.pc_preload = opcode_q[11:0] + {4'b0000, v0};
        end
        unique case (state)
            ST_HI_REQ, ST_LO_REQ:   bus.mem_rd_stb = 1'b1;
            ST_HI_WAIT, ST_LO_WAIT: bus.pc_inc_stb = bus.mem_rd_valid;
            ST_DECODE: begin
                if (is_ret) begin
                    stk_pop            = !stk_empty;
                    bus.pc_preload_stb = !stk_empty;
                end else if (is_call) begin
                    stk_push           = !stk_full;
                    bus.pc_preload_stb = !stk_full;
                end else if (is_jp || is_jpv0) begin
                    bus.pc_preload_stb = 1'b1;
                end
            end
            ST_EXEC: begin
                bus.opcode_valid     = 1'b1;
                bus.pc_jump_next_stb = bus.exec_done && bus.skip_cond;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and flow-control sequencer for the CHIP-8 core.
- Drives the program counter's strobe inputs and fetches the two opcode bytes from byte-wide memory at the PC.
- Resolves jump, call, return and jump-plus-V0 opcodes locally, using a 16-entry call stack.
- Hands all other opcodes to the execute unit and applies a skip (PC+2) when that unit reports a true condition.

## Interface
Parameters:
- STACK_DEPTH, 16, call-stack entries (power of two).

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable. Sampled only in IDLE.
- pc_value  in  12  current PC register output.
- pc_preload  out  12  load value for the PC.
- pc_preload_stb  out  1  load PC with pc_preload.
- pc_jump_next_stb  out  1  PC += 2.
- pc_inc_stb  out  1  PC += 1.
- mem_rd_stb  out  1  one-cycle read request; address is pc_value.
- mem_rd_data  in  8  read byte.
- mem_rd_valid  in  1  mem_rd_data valid; earliest one cycle after mem_rd_stb.
- v0  in  8  register V0, used by BNNN.
- opcode  out  16  latched opcode.
- opcode_valid  out  1  opcode offered to the execute unit.
- exec_done  in  1  execute unit finished.
- skip_cond  in  1  skip request; qualified by exec_done.
- fault  out  1  sticky stack overflow/underflow flag.

## Operation
- States: IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, DECODE, EXEC, FAULT.
- IDLE: if run=1, go to HI_REQ.
- HI_REQ: assert mem_rd_stb; go to HI_WAIT.
- HI_WAIT: on mem_rd_valid, latch opcode[15:8], pulse pc_inc_stb, go to LO_REQ.
- LO_REQ / LO_WAIT: same as the HI states, latching opcode[7:0].
- DECODE, by opcode class:
  - 1NNN: preload NNN.
  - 2NNN: push pc_value (next instruction address), preload NNN. If the stack is full, go to FAULT with no push and no preload.
  - 00EE: pop, preload the popped value. If the stack is empty, go to FAULT.
  - BNNN: preload (NNN + {4'b0,v0}) mod 4096.
  - Each of the above then returns to IDLE.
  - Any other opcode: go to EXEC.
- EXEC: opcode_valid=1. On exec_done: if skip_cond, pulse pc_jump_next_stb. Go to IDLE.
- FAULT: fault=1, all strobes 0. Leave only via rst.
- Strobes and opcode_valid are combinational decodes of state and inputs, exactly one cycle wide.
- Ignored inputs:
  - mem_rd_valid outside the WAIT states.
  - exec_done and skip_cond outside EXEC.
  - run outside IDLE: deasserting run mid-instruction completes that instruction.
- Stack: depth counter 0..STACK_DEPTH. Push writes at sp then increments; pop decrements then reads.

## Timing
- Reset (async): state IDLE; sp=0; depth=0; opcode=0x0000; pc_preload=0; all strobes 0; opcode_valid=0; fault=0.
- PC updates on the edge that ends a strobe cycle, so the next REQ or DECODE sees the updated pc_value.
- With single-cycle memory:
  - Flow-control instruction: 5 cycles, HI_REQ through DECODE.
  - Executed instruction: 5 cycles + EXEC wait ≥1 cycle.
- pc_preload is stable in the same cycle as pc_preload_stb.
- Push and preload in a 2NNN DECODE occur in the same cycle.
- Reset mid-operation aborts any pending read or exec handshake. Stack contents become don't-care.

## Structure
- Shared package/header chip8_pkg:
  - FSM state encodings.
  - Opcode class constants: OP_JP=4'h1, OP_CALL=4'h2, OP_JPV0=4'hB, RET=16'h00EE.
  - PC width (12).
- Sub-module call_stack.
  - Ports: clk, rst, push, pop, din[11:0], dout[11:0], full, empty.
  - Async reset of sp and depth only.

## Test plan
- Reset: assert rst mid-HI_WAIT → all outputs 0, state IDLE, fault=0; after release with run=1, HI_REQ on the next cycle.
- Jump: bytes 0x12,0x34 at 0x000 → pc_inc_stb twice, then pc_preload=0x234 with pc_preload_stb for one cycle; next mem_rd_stb sees pc_value=0x234.
- Call/return: 0x23,0x00 at 0x010; 0x00,0xEE at 0x300 → push 0x012, preload 0x300; return preloads 0x012; depth back to 0.
- Skip: opcode 0x3A05 at 0x020, exec_done=1, skip_cond=1 → one pc_jump_next_stb, next fetch at 0x024. With skip_cond=0 → next fetch at 0x022.
- BNNN wrap: opcode 0xBF80, v0=0xFF → pc_preload=0x07F.
- Stack limits: 17 nested calls → 17th raises fault with no preload, strobes stay 0 until rst. Separately, 00EE with an empty stack → fault.
